pipe_stage_reg: RTL and testbench

//  Parametrised pipeline-stage register: successor to the single-bit D flip-flop.
//  - Carries a WIDTH-bit payload between pipeline stages of the RISC-V core.
//  - valid/ready handshake with a 2-entry skid buffer:
//    - full throughput (1 beat/cycle);
//    - in_ready is a registered function of state (no ready combinational path).
//  - Synchronous flush for branch/exception squash.

---
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with 2-entry skid buffer
//
// Purpose:
//   Moves a WIDTH-bit payload between pipeline stages at one beat per cycle.
//   A main register (M) drives out_data directly; a skid register (S) absorbs
//   the one beat that can arrive while downstream stalls, so in_ready can be
//   a registered function of state with no combinational path from out_ready.
//   flush squashes everything held plus any beat arriving in the same cycle.
//
// Parameters:
//   WIDTH      payload width in bits (>= 1)
//   RESET_VAL  value loaded into M and S on reset and flush
//   CNT_W      stall counter width (only meaningful with the macro below)
//
// Optional feature:
//   PIPE_STAGE_STALL_CNT_EN  adds the stall_cnt output, a saturating count of
//                            cycles spent with out_valid & !out_ready
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        asynchronous active-low reset
//   flush      synchronous squash
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload
//   out_valid  stage holds a beat for downstream
//   out_ready  downstream accepts the beat this cycle
//   out_data   payload, straight from M
//   stall_cnt  (optional) downstream stall cycle count

module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_reg: WIDTH and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             acc;
  logic             pop;

  assign acc      = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_q;

  // in_ready and out_valid are kept as flops that always track
  // (state != FULL) and (state != EMPTY); they are updated together with
  // state so neither depends combinationally on the handshake inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      // A same-cycle pop has already been taken by downstream; a same-cycle
      // accept is simply never stored.
      state     <= ST_EMPTY;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            state     <= ST_ONE;
            main_q    <= in_data;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            main_q <= in_data;
          end else if (acc) begin
            state    <= ST_FULL;
            skid_q   <= in_data;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no accept can coincide with this pop.
          if (pop) begin
            state    <= ST_ONE;
            main_q   <= skid_q;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg at WIDTH=64 and WIDTH=1

module tb_pipe_stage_reg;

  localparam logic [63:0] RV64 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic        RV1  = 1'b1;
  localparam int          CMAX = 7;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        in_data1;
  logic        in_ready1;
  logic        out_valid1;
  logic        out_data1;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [2:0]  stall_cnt;
  logic [2:0]  stall_cnt1;
`endif

  assign in_data1 = in_data[0];

  pipe_stage_reg #(.WIDTH(64), .RESET_VAL(RV64), .CNT_W(3)) u_dut (
    .clk       (clk),
    .rst       (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  pipe_stage_reg #(.WIDTH(1), .RESET_VAL(RV1), .CNT_W(3)) u_dut1 (
    .clk       (clk),
    .rst       (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;

  // Reference model: the stage is a FIFO of capacity 2; its head is what
  // out_data shows, and when empty out_data shows the last beat handed over
  // (or RESET_VAL after reset/flush).
  logic [63:0] q[$];
  logic [63:0] idle_data = RV64;
  logic        idle1     = RV1;
  int          m_cnt     = 0;
  logic        cap_ready = 1'b0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    idle_data = RV64;
    idle1     = RV1;
    m_cnt     = 0;
    prev_hold = 1'b0;
    cap_ready = 1'b0;
  endtask

  // Stimulus side of the scoreboard: every accepted beat becomes an
  // expected output.
  always @(posedge clk) begin
    if (rst_n && !flush && in_valid && cap_ready) begin
      q.push_back(in_data);
      n_beats++;
    end
  end

  // Monitor: mid-cycle, compare DUT outputs with the expected head, then
  // retire the head if downstream takes it at the coming edge.
  always @(negedge clk) begin
    logic        exp_valid;
    logic [63:0] exp_d;
    logic        exp_d1;
    exp_valid = (q.size() > 0);
    exp_d     = exp_valid ? q[0] : idle_data;
    exp_d1    = exp_valid ? q[0][0] : idle1;
    chk("out_valid",    {63'd0, out_valid},  {63'd0, exp_valid});
    chk("in_ready",     {63'd0, in_ready},   {63'd0, q.size() < 2});
    chk("out_data",     out_data,            exp_d);
    chk("out_valid_w1", {63'd0, out_valid1}, {63'd0, exp_valid});
    chk("in_ready_w1",  {63'd0, in_ready1},  {63'd0, q.size() < 2});
    chk("out_data_w1",  {63'd0, out_data1},  {63'd0, exp_d1});
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_cnt",    {61'd0, stall_cnt},  64'(m_cnt));
    chk("stall_cnt_w1", {61'd0, stall_cnt1}, 64'(m_cnt));
`endif
    if (prev_hold) begin
      chk("stable_valid", {63'd0, out_valid}, 64'd1);
      chk("stable_data",  out_data,           prev_data);
    end
    if (rst_n) begin
      cap_ready = (q.size() < 2);
      prev_hold = exp_valid && !out_ready && !flush;
      prev_data = exp_d;
      if (flush) m_cnt = 0;
      else if (exp_valid && !out_ready && m_cnt < CMAX) m_cnt++;
      if (exp_valid && out_ready) begin
        idle_data = q[0];
        idle1     = q[0][0];
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
        idle_data = RV64;
        idle1     = RV1;
      end
    end else begin
      cap_ready = 1'b0;
      prev_hold = 1'b0;
    end
  end

  task automatic drive(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset_out_data",  out_data,           RV64);
    rst_n = 1'b1;

    // Streaming: data 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b1, 1'b0);
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, 64'bx, 1'b1, 1'b0);
    drive(1'b0, 64'bx, 1'b1, 1'b0);

    // Backpressure into the skid register, then drain.
    drive(1'b1, 64'hAAAA_0000_0000_000A, 1'b0, 1'b0);
    drive(1'b1, 64'hBBBB_0000_0000_000B, 1'b0, 1'b0);
    chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
    chk("skid_out_data", out_data, 64'hAAAA_0000_0000_000A);
    drive(1'b0, 64'bx, 1'b0, 1'b0);
    chk("skid_held_data", out_data, 64'hAAAA_0000_0000_000A);
    drive(1'b0, 64'bx, 1'b1, 1'b0);
    chk("skid_second", out_data, 64'hBBBB_0000_0000_000B);
    drive(1'b0, 64'bx, 1'b1, 1'b0);
    chk("skid_drained", {63'd0, out_valid}, 64'd0);

    // Flush while FULL with a beat offered in the same cycle.
    drive(1'b1, 64'h1111_0000_0000_0001, 1'b0, 1'b0);
    drive(1'b1, 64'h2222_0000_0000_0002, 1'b0, 1'b0);
    drive(1'b1, 64'h3333_0000_0000_0003, 1'b0, 1'b1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
    chk("flush_out_data",  out_data,           RV64);
    for (int i = 0; i < 3; i++) drive(1'b0, 64'bx, 1'b1, 1'b0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Saturating stall count at CNT_W=3, then cleared by flush.
    drive(1'b1, 64'h4444_0000_0000_0004, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 64'bx, 1'b0, 1'b0);
    chk("stall_saturated", {61'd0, stall_cnt}, 64'd7);
    drive(1'b0, 64'bx, 1'b0, 1'b1);
    chk("stall_flushed", {61'd0, stall_cnt}, 64'd0);
`endif

    // Asynchronous reset while FULL takes effect before the next edge.
    drive(1'b1, 64'h5555_0000_0000_0005, 1'b0, 1'b0);
    drive(1'b1, 64'h6666_0000_0000_0006, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_in_ready",  {63'd0, in_ready},  64'd1);
    chk("async_out_data",  out_data,           RV64);
    chk("async_out_data1", {63'd0, out_data1}, {63'd0, RV1});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic, X on in_data whenever in_valid is low.
    n_beats = 0;
    cyc     = 0;
    while (n_beats < 10000 && cyc < 40000) begin
      logic iv, ordy, fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 255) == 0);
      drive(iv, iv ? {$urandom, $urandom} : 64'bx, ordy, fl);
      cyc++;
    end
    chk("random_beats_done", 64'(n_beats >= 10000), 64'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, 64'bx, 1'b1, 1'b0);
    chk("final_empty", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
